// File: rtl/lut_cu_pipe.sv
// RV32I(+M) control unit: decodes one instruction per cycle into a 25-bit control word
// and carries it down a stallable, per-stage flushable control pipeline.
module lut_cu_pipe #(
   parameter int NUM_STAGES = 3,
   parameter int EN_M       = 0,
   parameter int CNT_W      = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     En,
   input  logic [31:0]              Instr,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic                     Stall,
   input  logic [NUM_STAGES-1:0]    Flush,
   output logic [NUM_STAGES*25-1:0] CtrlWrd,
   output logic [NUM_STAGES-1:0]    CtrlVld,
   output logic [CNT_W-1:0]         IllegalCnt
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA
   function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic        legal;
   logic        br_en;
   logic        jal;
   logic        jalr;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_uns;
   logic        wb_en;
   logic [1:0]  wb_sel;
   logic        src_a;
   logic        src_b;
   logic [2:0]  imm_type;
   logic [4:0]  alu_op;
   logic [24:0] dec_word;
   logic        bubble;

   assign opcode = Instr[6:0];
   assign rd     = Instr[11:7];
   assign f3     = Instr[14:12];
   assign f7     = Instr[31:25];

   always_comb begin
      legal    = 1'b1;
      br_en    = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_size = 2'd0;
      mem_uns  = 1'b0;
      wb_en    = 1'b0;
      wb_sel   = WB_ALU;
      src_a    = 1'b0;
      src_b    = 1'b0;
      imm_type = IMM_I;
      alu_op   = ALU_ADD;
      case (opcode)
         OP_LUI: begin
            wb_en    = 1'b1;
            src_b    = 1'b1;
            imm_type = IMM_U;
            alu_op   = ALU_PASSB;
         end
         OP_AUIPC: begin
            wb_en    = 1'b1;
            src_a    = 1'b1;
            src_b    = 1'b1;
            imm_type = IMM_U;
         end
         OP_JAL: begin
            jal      = 1'b1;
            wb_en    = 1'b1;
            wb_sel   = WB_PC4;
            src_a    = 1'b1;
            src_b    = 1'b1;
            imm_type = IMM_J;
         end
         OP_JALR: begin
            legal  = (f3 == 3'b000);
            jalr   = 1'b1;
            wb_en  = 1'b1;
            wb_sel = WB_PC4;
            src_b  = 1'b1;
         end
         OP_BRANCH: begin
            legal    = (f3 != 3'b010) && (f3 != 3'b011);
            br_en    = 1'b1;
            imm_type = IMM_B;
         end
         OP_LOAD: begin
            legal    = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            mem_rd   = 1'b1;
            mem_size = f3[1:0];
            mem_uns  = f3[2];
            wb_en    = 1'b1;
            wb_sel   = WB_MEM;
            src_b    = 1'b1;
         end
         OP_STORE: begin
            legal    = (f3 <= 3'b010);
            mem_wr   = 1'b1;
            mem_size = f3[1:0];
            src_b    = 1'b1;
            imm_type = IMM_S;
         end
         OP_IMM: begin
            wb_en  = 1'b1;
            src_b  = 1'b1;
            alu_op = base_op(f3, (f3 == 3'b101) && f7[5]);
            // only the shift forms carry a funct7 field in the immediate
            if (f3 == 3'b001)
               legal = (f7 == F7_BASE);
            else if (f3 == 3'b101)
               legal = (f7 == F7_BASE) || (f7 == F7_ALT);
         end
         OP_REG: begin
            wb_en = 1'b1;
            if (f7 == F7_BASE)
               alu_op = base_op(f3, 1'b0);
            else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))
               alu_op = base_op(f3, 1'b1);
            else if ((f7 == F7_MUL) && (EN_M != 0))
               alu_op = {2'b10, f3};
            else
               legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
   end

   assign dec_word = legal ?
      {1'b0, br_en, (br_en ? f3 : 3'b000), jal, jalr, mem_rd, mem_wr, mem_size, mem_uns,
       wb_en & (rd != 5'd0), wb_sel, src_a, src_b, imm_type, alu_op} :
      25'h100_0000;

   assign bubble  = (Instr == 32'h0) || !En || !InValid;
   assign InReady = !Stall;

   logic [24:0]           stage_in_word [NUM_STAGES];
   logic [NUM_STAGES-1:0] stage_in_vld;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         logic [24:0] word_reg;
         logic        vld_reg;

         if (gi == 0) begin : g_src_dec
            assign stage_in_word[gi] = bubble ? 25'h0 : dec_word;
            assign stage_in_vld[gi]  = !bubble;
         end else begin : g_src_prev
            assign stage_in_word[gi] = CtrlWrd[25*(gi-1) +: 25];
            assign stage_in_vld[gi]  = CtrlVld[gi-1];
         end

         always_ff @(posedge Clk) begin
            if (Rst || Flush[gi]) begin
               word_reg <= 25'h0;
               vld_reg  <= 1'b0;
            end else if (!Stall) begin
               word_reg <= stage_in_word[gi];
               vld_reg  <= stage_in_vld[gi];
            end
         end

         assign CtrlWrd[25*gi +: 25] = word_reg;
         assign CtrlVld[gi]          = vld_reg;
      end
   endgenerate

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge Clk) begin
      if (Rst)
         cnt_reg <= '0;
      else if (!Flush[0] && !Stall && !bubble && !legal && (cnt_reg != {CNT_W{1'b1}}))
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign IllegalCnt = cnt_reg;

endmodule
